main_controller: RTL and testbench

- Multicycle MIPS main control FSM. Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives all datapath enables and mux selects for those steps.
- Produces the 2-bit alu_op consumed by the downstream ALU function decoder.
- Also keeps free-running cycle and retired-instruction counters for bring-up and performance checks.

---
 rtl/main_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_main_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/main_controller.sv
// Multicycle MIPS main control FSM with free-running cycle and retired-instruction counters.
// Build option: define BNE_EN to add the bne instruction (BNE state, pc_en = ~zero there).
//
// state   | meaning
// --------+-----------------------------------------------
// FETCH   | load IR, PC <= PC + 4
// DECODE  | register read, branch target precompute
// MEMADR  | lw/sw address = A + sign-extended immediate
// MEMRD   | read data memory at ALUOut
// MEMWB   | write loaded data to rt
// MEMWR   | write B to data memory at ALUOut
// EXECUTE | R-type ALU operation on A, B
// ALUWB   | write ALUOut to rd
// BRANCH  | beq compare, PC <= target when equal
// ADDIEX  | A + sign-extended immediate
// IMMWB   | write ALUOut to rt
// JUMP    | PC <= jump target
// ANDIEX  | A & zero-extended immediate
// BNE     | bne compare, PC <= target when not equal (BNE_EN only)
module main_controller #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [5:0]           op,
  input  logic                 zero,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 iord,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 imm_zext,
  output logic [1:0]           alu_op,
  output logic [1:0]           pc_src,
  output logic                 pc_en,
  output logic                 illegal_op,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instr_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [3:0] {
    S_FETCH   = 4'h0,
    S_DECODE  = 4'h1,
    S_MEMADR  = 4'h2,
    S_MEMRD   = 4'h3,
    S_MEMWB   = 4'h4,
    S_MEMWR   = 4'h5,
    S_EXECUTE = 4'h6,
    S_ALUWB   = 4'h7,
    S_BRANCH  = 4'h8,
    S_ADDIEX  = 4'h9,
    S_IMMWB   = 4'hA,
    S_JUMP    = 4'hB,
`ifdef BNE_EN
    S_BNE     = 4'hD,
`endif
    S_ANDIEX  = 4'hC
  } state_t;

  state_t state_q;
  state_t state_d;

  logic pc_write;
  logic branch;
  logic retiring;
`ifdef BNE_EN
  logic branch_ne;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    imm_zext   = 1'b0;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    illegal_op = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    retiring   = 1'b0;
`ifdef BNE_EN
    branch_ne  = 1'b0;
`endif

    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ANDI:      state_d = S_ANDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef BNE_EN
          OP_BNE:       state_d = S_BNE;
`endif
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // op is still held in the IR, so lw/sw can be re-examined here
        state_d   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retiring   = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        retiring  = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retiring  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
        retiring  = 1'b1;
      end
`ifdef BNE_EN
      S_BNE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch_ne = 1'b1;
        retiring  = 1'b1;
      end
`endif
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_IMMWB;
      end
      S_ANDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        imm_zext  = 1'b1;
        state_d   = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        retiring  = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retiring = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

`ifdef BNE_EN
  assign pc_en = pc_write | (branch & zero) | (branch_ne & ~zero);
`else
  assign pc_en = pc_write | (branch & zero);
`endif

  assign state = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_ONE;
      if (retiring) begin
        instr_cnt <= instr_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_main_controller.sv
// Self-checking bench for main_controller: per-state expectation table, directed corner
// sequences and randomized instruction streams against an instruction-level model.
module tb_main_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  op;
  logic        zero;

  logic        mem_write, ir_write, iord, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic        imm_zext, pc_en, illegal_op;
  logic [3:0]  state;
  logic [31:0] cycle_cnt, instr_cnt;

  logic        mem_write_w, ir_write_w, iord_w, reg_dst_w, mem_to_reg_w, reg_write_w, alu_src_a_w;
  logic [1:0]  alu_src_b_w, alu_op_w, pc_src_w;
  logic        imm_zext_w, pc_en_w, illegal_op_w;
  logic [3:0]  state_w;
  logic [3:0]  cycle_cnt_w, instr_cnt_w;

  int n_checks = 0;
  int n_errors = 0;
  int m_cyc = 0;
  int m_ins = 0;

  typedef struct {
    logic [13:0] outs;
    bit          pcw;
    bit          br;
    bit          bn;
  } exp_t;
  exp_t tbl [16];

  logic [5:0] legal_ops [8];

  main_controller #(.CNT_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero),
    .mem_write(mem_write), .ir_write(ir_write), .iord(iord), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_zext(imm_zext), .alu_op(alu_op), .pc_src(pc_src),
    .pc_en(pc_en), .illegal_op(illegal_op), .state(state),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  main_controller #(.CNT_WIDTH(4)) dut_w (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero),
    .mem_write(mem_write_w), .ir_write(ir_write_w), .iord(iord_w), .reg_dst(reg_dst_w),
    .mem_to_reg(mem_to_reg_w), .reg_write(reg_write_w), .alu_src_a(alu_src_a_w),
    .alu_src_b(alu_src_b_w), .imm_zext(imm_zext_w), .alu_op(alu_op_w), .pc_src(pc_src_w),
    .pc_en(pc_en_w), .illegal_op(illegal_op_w), .state(state_w),
    .cycle_cnt(cycle_cnt_w), .instr_cnt(instr_cnt_w)
  );

  always #5 clk = ~clk;

  logic [13:0] outs;
  assign outs = {mem_write, ir_write, iord, reg_dst, mem_to_reg, reg_write, alu_src_a,
                 alu_src_b, imm_zext, alu_op, pc_src};

  function automatic logic [13:0] mk(input bit mw, input bit irw, input bit io, input bit rd,
                                     input bit m2r, input bit rw, input bit asa,
                                     input logic [1:0] asb, input bit iz,
                                     input logic [1:0] aop, input logic [1:0] ps);
    return {mw, irw, io, rd, m2r, rw, asa, asb, iz, aop, ps};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Executes one instruction from FETCH; the path is the architectural step list for op.
  task automatic run_instr(input logic [5:0] o, input int zmode);
    int  path[$];
    bit  ill;
    int  s;
    bit  exp_pc;
    path = {0, 1};
    case (o)
      6'b100011: path = {0, 1, 2, 3, 4};
      6'b101011: path = {0, 1, 2, 5};
      6'b000000: path = {0, 1, 6, 7};
      6'b000100: path = {0, 1, 8};
      6'b001000: path = {0, 1, 9, 10};
      6'b001100: path = {0, 1, 12, 10};
      6'b000010: path = {0, 1, 11};
`ifdef BNE_EN
      6'b000101: path = {0, 1, 13};
`endif
      default:   path = {0, 1};
    endcase
    ill = (path.size() == 2);
    op = o;
    for (int i = 0; i < path.size(); i++) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      s = path[i];
      exp_pc = tbl[s].pcw | (tbl[s].br & zero) | (tbl[s].bn & ~zero);
      chk("state", 32'(state), 32'(s));
      chk("outputs", 32'(outs), 32'(tbl[s].outs));
      chk("pc_en", 32'(pc_en), 32'(exp_pc));
      chk("illegal_op", 32'(illegal_op), 32'((s == 1) && ill));
      chk("cycle_cnt", cycle_cnt, 32'(m_cyc));
      chk("instr_cnt", instr_cnt, 32'(m_ins));
      chk("cycle_cnt_w", 32'(cycle_cnt_w), 32'(m_cyc % 16));
      chk("instr_cnt_w", 32'(instr_cnt_w), 32'(m_ins % 16));
      @(posedge clk);
      m_cyc++;
      if (i == path.size() - 1 && !ill) m_ins++;
      @(negedge clk);
    end
  endtask

  initial begin
    tbl[0]  = '{mk(0,1,0,0,0,0,0,2'b01,0,2'b00,2'b00), 1, 0, 0};
    tbl[1]  = '{mk(0,0,0,0,0,0,0,2'b11,0,2'b00,2'b00), 0, 0, 0};
    tbl[2]  = '{mk(0,0,0,0,0,0,1,2'b10,0,2'b00,2'b00), 0, 0, 0};
    tbl[3]  = '{mk(0,0,1,0,0,0,0,2'b00,0,2'b00,2'b00), 0, 0, 0};
    tbl[4]  = '{mk(0,0,0,0,1,1,0,2'b00,0,2'b00,2'b00), 0, 0, 0};
    tbl[5]  = '{mk(1,0,1,0,0,0,0,2'b00,0,2'b00,2'b00), 0, 0, 0};
    tbl[6]  = '{mk(0,0,0,0,0,0,1,2'b00,0,2'b10,2'b00), 0, 0, 0};
    tbl[7]  = '{mk(0,0,0,1,0,1,0,2'b00,0,2'b00,2'b00), 0, 0, 0};
    tbl[8]  = '{mk(0,0,0,0,0,0,1,2'b00,0,2'b01,2'b01), 0, 1, 0};
    tbl[9]  = '{mk(0,0,0,0,0,0,1,2'b10,0,2'b00,2'b00), 0, 0, 0};
    tbl[10] = '{mk(0,0,0,0,0,1,0,2'b00,0,2'b00,2'b00), 0, 0, 0};
    tbl[11] = '{mk(0,0,0,0,0,0,0,2'b00,0,2'b00,2'b10), 1, 0, 0};
    tbl[12] = '{mk(0,0,0,0,0,0,1,2'b10,1,2'b11,2'b00), 0, 0, 0};
    tbl[13] = '{mk(0,0,0,0,0,0,1,2'b00,0,2'b01,2'b01), 0, 0, 1};
    tbl[14] = '{14'd0, 0, 0, 0};
    tbl[15] = '{14'd0, 0, 0, 0};
    legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                  6'b001000, 6'b001100, 6'b000010, 6'b000101};

    reset_n = 1'b0;
    op = 6'b000000;
    zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_ir_write", 32'(ir_write), 32'h1);
    chk("rst_pc_en", 32'(pc_en), 32'h1);
    chk("rst_alu_src_b", 32'(alu_src_b), 32'h1);
    chk("rst_cycle_cnt", cycle_cnt, 32'h0);
    chk("rst_instr_cnt", instr_cnt, 32'h0);
    reset_n = 1'b1;

    // Four R-type instructions take exactly 16 cycles: the 4-bit counter wraps to 0.
    for (int k = 0; k < 4; k++) run_instr(6'b000000, 2);
    chk("cycle_wrap_w", 32'(cycle_cnt_w), 32'h0);
    chk("cycle_16", cycle_cnt, 32'd16);
    chk("instr_4", instr_cnt, 32'd4);

    run_instr(6'b100011, 2);
    run_instr(6'b101011, 2);
    run_instr(6'b000100, 1);
    run_instr(6'b000100, 0);
    run_instr(6'b001100, 2);
    run_instr(6'b001000, 2);
    run_instr(6'b000010, 2);
    run_instr(6'b111111, 2);
    run_instr(6'b000101, 1);
    run_instr(6'b000101, 0);

    // Reset asserted while in MEMRD of a lw.
    op = 6'b100011;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("midrst_pre_state", 32'(state), 32'h3);
    reset_n = 1'b0;
    #1;
    chk("midrst_state", 32'(state), 32'h0);
    chk("midrst_reg_write", 32'(reg_write), 32'h0);
    chk("midrst_cycle_cnt", cycle_cnt, 32'h0);
    chk("midrst_instr_cnt", instr_cnt, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_hold_reg_write", 32'(reg_write), 32'h0);
      chk("midrst_hold_state", 32'(state), 32'h0);
    end
    m_cyc = 0;
    m_ins = 0;
    reset_n = 1'b1;
    run_instr(6'b100011, 2);

    for (int k = 0; k < 120; k++) begin
      logic [5:0] o;
      if ($urandom_range(0, 9) < 8) o = legal_ops[$urandom_range(0, 7)];
      else o = 6'($urandom);
      run_instr(o, 2);
    end
    #1;
    chk("final_state", 32'(state), 32'h0);
    chk("final_instr_cnt", instr_cnt, 32'(m_ins));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
